// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared states and command/response codes for the UART memory loader
package loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CSUM,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_CAP,
        ST_TX_RESP,
        ST_TX_DATA
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_HOLD  = 8'h03;
    localparam logic [7:0] CMD_RUN   = 8'h04;
    localparam logic [7:0] ACK_BYTE  = 8'h5A;
    localparam logic [7:0] NAK_BYTE  = 8'hEE;

    function automatic logic accepts_rx(input state_t s);
        return s inside {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_CSUM};
    endfunction

    function automatic logic in_frame(input state_t s);
        return s inside {ST_CMD, ST_ADDR, ST_DATA, ST_CSUM};
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - clearable idle counter that pulses expired after TIMEOUT_CYCLES quiet cycles
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        expired = 1'b0;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
            expired = 1'b1;
            count_d = '0;
        end else begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - UART frame to bus access bridge; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module uart_mem_loader
    import loader_pkg::*;
#(
    parameter int         WIDTH          = 32,
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic       HOLD_AT_RESET  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] bus_address,
    output logic [WIDTH-1:0] bus_w_data,
    output logic             bus_we,
    output logic             bus_re,
    input  logic [WIDTH-1:0] bus_r_data,
    output logic             core_hold,
    output logic             busy
);

    localparam int NB = WIDTH / 8;
    localparam int IW = $clog2(NB);

    state_t           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             hold_q, hold_d;
    logic             rx_ready_q, rx_ready_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             bus_we_q, bus_we_d;
    logic             bus_re_q, bus_re_d;
    logic             core_hold_q, core_hold_d;
    logic             busy_q, busy_d;

    logic rx_fire, tx_fire, byte_last, frame_done, timed_out;

    assign rx_fire   = rx_valid & rx_ready_q;
    assign tx_fire   = tx_valid_q & tx_ready;
    assign byte_last = (idx_q == IW'(NB - 1));

    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (rx_fire),
        .enable  (in_frame(state_q)),
        .expired (timed_out)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        bus_we_d   = 1'b0;
        bus_re_d   = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_fire && rx_data == SYNC_BYTE) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_fire) begin
                    cmd_d   = rx_data;
                    csum_d  = rx_data;
                    idx_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_fire) begin
                    shift_d = {rx_data, shift_q[WIDTH-1:8]};
                    csum_d  = csum_q ^ rx_data;
                    idx_d   = idx_q + IW'(1);
                    if (byte_last) begin
                        addr_d = shift_d;
                        if (cmd_q == CMD_WRITE) begin
                            state_d = ST_DATA;
                        end else begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            frame_done = 1'b1;
`endif
                        end
                    end
                end
            end
            ST_DATA: begin
                if (rx_fire) begin
                    shift_d = {rx_data, shift_q[WIDTH-1:8]};
                    csum_d  = csum_q ^ rx_data;
                    idx_d   = idx_q + IW'(1);
                    if (byte_last) begin
                        wdata_d = shift_d;
`ifdef LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_fire) begin
                    if (rx_data == csum_q) begin
                        frame_done = 1'b1;
                    end else begin
                        tx_data_d  = NAK_BYTE;
                        tx_valid_d = 1'b1;
                        state_d    = ST_TX_RESP;
                    end
                end
            end
`endif
            ST_BUS_WR: begin
                tx_data_d  = ACK_BYTE;
                tx_valid_d = 1'b1;
                state_d    = ST_TX_RESP;
            end
            ST_BUS_RD: begin
                shift_d = bus_r_data;
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                tx_data_d  = shift_q[7:0];
                tx_valid_d = 1'b1;
                idx_d      = '0;
                state_d    = ST_TX_DATA;
            end
            ST_TX_RESP: begin
                if (tx_fire) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_TX_DATA: begin
                if (tx_fire) begin
                    if (byte_last) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        shift_d   = shift_q >> 8;
                        tx_data_d = shift_d[7:0];
                        idx_d     = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Last frame byte accepted and checked: launch the access or flag change next cycle.
        if (frame_done) begin
            tx_data_d  = ACK_BYTE;
            tx_valid_d = 1'b1;
            state_d    = ST_TX_RESP;
            case (cmd_q)
                CMD_WRITE: begin
                    tx_valid_d = 1'b0;
                    bus_we_d   = 1'b1;
                    state_d    = ST_BUS_WR;
                end
                CMD_READ: begin
                    tx_valid_d = 1'b0;
                    bus_re_d   = 1'b1;
                    state_d    = ST_BUS_RD;
                end
                CMD_HOLD: hold_d = 1'b1;
                CMD_RUN:  hold_d = 1'b0;
                default:  tx_data_d = NAK_BYTE;
            endcase
        end

        if (timed_out) begin
            state_d = ST_IDLE;
        end

        rx_ready_d  = accepts_rx(state_d);
        busy_d      = (state_d != ST_IDLE);
        core_hold_d = hold_d | (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            csum_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hold_q      <= HOLD_AT_RESET;
            rx_ready_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            core_hold_q <= HOLD_AT_RESET;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            rx_ready_q  <= rx_ready_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
            core_hold_q <= core_hold_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign bus_address = addr_q;
    assign bus_w_data  = wdata_q;
    assign bus_we      = bus_we_q;
    assign bus_re      = bus_re_q;
    assign core_hold   = core_hold_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed bench for uart_mem_loader; frames carry a CSUM byte when LOADER_CHECKSUM_EN is defined
module tb_uart_mem_loader;

    localparam int TO = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [31:0] bus_address, bus_w_data, bus_r_data = '0;
    logic        bus_we, bus_re, core_hold, busy;

    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    logic [31:0] we_addr = '0, we_data = '0;
    logic [7:0]  txq[$];
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_err = 8'h00;
`endif

    uart_mem_loader #(.WIDTH(32), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5), .HOLD_AT_RESET(1'b0)) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .bus_address (bus_address),
        .bus_w_data  (bus_w_data),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_r_data  (bus_r_data),
        .core_hold   (core_hold),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus_we) begin
            we_cnt++;
            we_addr = bus_address;
            we_data = bus_w_data;
        end
        if (bus_re) re_cnt++;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            cycles(1);
            n++;
        end
        if (n >= 100) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        cycles(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        logic [7:0] b[$];
        b = {8'hA5, cmd, addr[7:0], addr[15:8], addr[23:16], addr[31:24]};
        if (cmd == 8'h01) begin
            b.push_back(data[7:0]);
            b.push_back(data[15:8]);
            b.push_back(data[23:16]);
            b.push_back(data[31:24]);
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] cs;
            cs = 8'h00;
            for (int i = 1; i < b.size(); i++) cs ^= b[i];
            b.push_back(cs ^ csum_err);
        end
`endif
        foreach (b[i]) send_byte(b[i]);
    endtask

    task automatic wait_tx(input int n, input string tag);
        int k;
        k = 0;
        while (txq.size() < n && k < 500) begin
            cycles(1);
            k++;
        end
        check(tag, 32'(txq.size()), 32'(n));
    endtask

    initial begin
        logic stable;
        int we0, re0;

        // Reset values
        cycles(2);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_re", 32'(bus_re), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_hold", 32'(core_hold), 32'd0);
        check("rst_bus_address", bus_address, 32'd0);
        reset = 1'b1;
        cycles(1);
        check("idle_rx_ready", 32'(rx_ready), 32'd1);

        // WRITE 0xDEADBEEF to 0x100
        send_frame(8'h01, 32'h0000_0100, 32'hDEAD_BEEF);
        check("wr_bus_we", 32'(bus_we), 32'd1);
        check("wr_addr", bus_address, 32'h0000_0100);
        check("wr_data", bus_w_data, 32'hDEAD_BEEF);
        check("wr_core_hold", 32'(core_hold), 32'd1);
        check("wr_rx_ready", 32'(rx_ready), 32'd0);
        wait_tx(1, "wr_tx_count");
        check("wr_ack", 32'(txq[0]), 32'h5A);
        check("wr_we_cycles", 32'(we_cnt), 32'd1);
        cycles(2);
        check("wr_busy_after", 32'(busy), 32'd0);
        check("wr_hold_after", 32'(core_hold), 32'd0);
        txq.delete();

        // READ 0x100 returns 0x12345678 little-endian
        bus_r_data = 32'h1234_5678;
        send_frame(8'h02, 32'h0000_0100, 32'h0);
        check("rd_bus_re", 32'(bus_re), 32'd1);
        wait_tx(4, "rd_tx_count");
        check("rd_b0", 32'(txq[0]), 32'h78);
        check("rd_b1", 32'(txq[1]), 32'h56);
        check("rd_b2", 32'(txq[2]), 32'h34);
        check("rd_b3", 32'(txq[3]), 32'h12);
        check("rd_re_cycles", 32'(re_cnt), 32'd1);
        check("rd_no_we", 32'(we_cnt), 32'd1);
        txq.delete();

        // HOLD keeps core_hold through a READ; RUN releases it
        send_frame(8'h03, 32'h0, 32'h0);
        wait_tx(1, "hold_tx_count");
        check("hold_ack", 32'(txq[0]), 32'h5A);
        txq.delete();
        send_frame(8'h02, 32'h0000_0004, 32'h0);
        wait_tx(4, "hold_rd_tx_count");
        txq.delete();
        cycles(3);
        check("hold_core_hold", 32'(core_hold), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        send_frame(8'h04, 32'h0, 32'h0);
        wait_tx(1, "run_tx_count");
        check("run_ack", 32'(txq[0]), 32'h5A);
        txq.delete();
        cycles(2);
        check("run_core_hold", 32'(core_hold), 32'd0);

        // Timeout after two ADDR bytes
        we0 = we_cnt;
        send_byte(8'hA5);
        check("sync_core_hold", 32'(core_hold), 32'd1);
        check("sync_busy", 32'(busy), 32'd1);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h01);
        cycles(TO - 1);
        check("to_busy_before", 32'(busy), 32'd1);
        cycles(1);
        check("to_busy_after", 32'(busy), 32'd0);
        check("to_core_hold", 32'(core_hold), 32'd0);
        check("to_no_we", 32'(we_cnt), 32'(we0));
        check("to_no_tx", 32'(txq.size()), 32'd0);

        // Unknown command NAK under TX backpressure
        re0 = re_cnt;
        tx_ready = 1'b0;
        send_frame(8'h07, 32'h0000_0010, 32'h0);
        cycles(2);
        check("nak_tx_valid", 32'(tx_valid), 32'd1);
        check("nak_tx_data", 32'(tx_data), 32'hEE);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycles(1);
            if (tx_valid !== 1'b1 || tx_data !== 8'hEE) stable = 1'b0;
        end
        check("nak_stable", 32'(stable), 32'd1);
        check("nak_busy", 32'(busy), 32'd1);
        tx_ready = 1'b1;
        wait_tx(1, "nak_tx_count");
        check("nak_byte", 32'(txq[0]), 32'hEE);
        check("nak_no_we", 32'(we_cnt), 32'(we0));
        check("nak_no_re", 32'(re_cnt), 32'(re0));
        txq.delete();

`ifdef LOADER_CHECKSUM_EN
        csum_err = 8'h40;
        send_frame(8'h01, 32'h0000_0200, 32'h0102_0304);
        csum_err = 8'h00;
        wait_tx(1, "cs_bad_tx_count");
        check("cs_bad_nak", 32'(txq[0]), 32'hEE);
        check("cs_bad_no_we", 32'(we_cnt), 32'(we0));
        txq.delete();
        send_frame(8'h01, 32'h0000_0200, 32'h0102_0304);
        wait_tx(1, "cs_ok_tx_count");
        check("cs_ok_ack", 32'(txq[0]), 32'h5A);
        check("cs_ok_we", 32'(we_cnt), 32'(we0 + 1));
        check("cs_ok_addr", we_addr, 32'h0000_0200);
        check("cs_ok_data", we_data, 32'h0102_0304);
        txq.delete();
        we0 = we_cnt;
`endif

        // Reset in the middle of a WRITE frame
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_core_hold", 32'(core_hold), 32'd0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'd0);
        cycles(2);
        reset = 1'b1;
        cycles(3);
        check("mid_rst_no_we", 32'(we_cnt), 32'(we0));
        check("mid_rst_idle_ready", 32'(rx_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
